atm_txn_arbiter: RTL

//  Shares one ATM core among NUM_TERM terminals. Grants terminals round-robin, resets the core,

---
 rtl/atm_pkg.sv | 26 ++
 rtl/atm_rr_arbiter.sv | 20 ++
 rtl/atm_txn_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/atm_pkg.sv
// atm_pkg: shared field widths, opcodes, core state codes and arbiter FSM encoding
package atm_pkg;
    localparam int OP_W  = 3;
    localparam int ACC_W = 4;
    localparam int PIN_W = 16;
    localparam int AMT_W = 32;
    localparam int BAL_W = 32;
    localparam logic [OP_W-1:0] OP_SHOW_BAL = 3'd3;
    localparam logic [OP_W-1:0] OP_WITHDRAW = 3'd4;
    localparam logic [OP_W-1:0] OP_DEPOSIT  = 3'd5;
    localparam logic [OP_W-1:0] OP_PIN_CHG  = 3'd6;
    localparam logic [2:0] CORE_AUTH = 3'd3;
    localparam logic [2:0] CORE_IDLE = 3'd7;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CRST = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;
    typedef struct packed {
        logic [OP_W-1:0]  op;
        logic [ACC_W-1:0] acc;
        logic [PIN_W-1:0] pin;
        logic [PIN_W-1:0] newpin;
        logic [AMT_W-1:0] amount;
        logic             lang;
    } txn_t;
endpackage

// File: rtl/atm_rr_arbiter.sv
// atm_rr_arbiter: combinational round-robin pick of the first requester at or after the pointer
module atm_rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         i_req,
    input  logic [$clog2(N)-1:0] i_ptr,
    output logic [N-1:0]         o_grant,
    output logic [$clog2(N)-1:0] o_idx,
    output logic                 o_any
);
    localparam int PW = $clog2(N);
    always_comb begin
        o_idx = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[PW'((int'(i_ptr) + k) % N)]) o_idx = PW'((int'(i_ptr) + k) % N);
        end
    end
    assign o_any   = |i_req;
    assign o_grant = N'(o_any) << o_idx;
endmodule

// File: rtl/atm_txn_arbiter.sv
// atm_txn_arbiter: round-robin owner of the shared ATM core with per-terminal failure lockout
module atm_txn_arbiter
    import atm_pkg::*;
#(
    parameter int NUM_TERM  = 4,
    parameter int OP_CYCLES = 4,
    parameter int MAX_FAIL  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_TERM-1:0]       i_term_req,
    input  logic [OP_W*NUM_TERM-1:0]  i_term_op,
    input  logic [ACC_W*NUM_TERM-1:0] i_term_acc,
    input  logic [PIN_W*NUM_TERM-1:0] i_term_pin,
    input  logic [PIN_W*NUM_TERM-1:0] i_term_newpin,
    input  logic [AMT_W*NUM_TERM-1:0] i_term_amount,
    input  logic [NUM_TERM-1:0]       i_term_lang,
    output logic [NUM_TERM-1:0]       o_term_grant,
    output logic [NUM_TERM-1:0]       o_term_done,
    output logic [NUM_TERM-1:0]       o_term_locked,
    output logic [BAL_W-1:0]          o_rsp_balance,
    output logic                      o_rsp_success,
    output logic                      o_core_rst,
    output logic [OP_W-1:0]           o_core_op,
    output logic [ACC_W-1:0]          o_core_acc,
    output logic [PIN_W-1:0]          o_core_pin,
    output logic [PIN_W-1:0]          o_core_newpin,
    output logic [AMT_W-1:0]          o_core_amount,
    output logic                      o_core_lang,
    input  logic [BAL_W-1:0]          i_core_balance,
    input  logic                      i_core_success,
    input  logic [2:0]                i_core_state
);
    localparam int PW = $clog2(NUM_TERM);
    localparam int CW = $clog2(OP_CYCLES);
    localparam int FW = $clog2(MAX_FAIL + 1);
    logic [1:0]          r_state;
    logic [PW-1:0]       r_ptr, r_gidx;
    logic [CW-1:0]       r_cnt;
    logic [FW-1:0]       r_fail [NUM_TERM];
    logic [NUM_TERM-1:0] r_grant, r_done, r_locked;
    logic [BAL_W-1:0]    r_bal;
    logic                r_succ, r_core_rst;
    txn_t                r_txn;
    logic [NUM_TERM-1:0] w_elig, w_pick;
    logic [PW-1:0]       w_idx, w_nptr;
    logic [FW-1:0]       w_fail_nxt;
    logic                w_any, w_abort, w_expire, w_unused;
    atm_rr_arbiter #(.N(NUM_TERM)) u_rr (
        .i_req   (w_elig),
        .i_ptr   (r_ptr),
        .o_grant (w_pick),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );
    // a terminal whose done is showing this cycle still holds req; keep it out of this pick
    assign w_elig     = i_term_req & ~r_locked & ~r_done;
    assign w_abort    = (r_state == ST_CRST || r_state == ST_RUN) && !i_term_req[r_gidx];
    assign w_expire   = r_state == ST_RUN && r_cnt == CW'(OP_CYCLES - 1);
    assign w_nptr     = r_gidx == PW'(NUM_TERM - 1) ? '0 : r_gidx + 1'b1;
    assign w_fail_nxt = r_fail[r_gidx] + 1'b1;
    assign w_unused   = ^i_core_state;
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_gidx     <= '0;
            r_cnt      <= '0;
            r_grant    <= '0;
            r_done     <= '0;
            r_locked   <= '0;
            r_bal      <= '0;
            r_succ     <= 1'b0;
            r_core_rst <= 1'b0;
            r_txn      <= '0;
            for (int i = 0; i < NUM_TERM; i++) r_fail[i] <= '0;
        end else begin
            r_done     <= '0;
            r_core_rst <= 1'b1;
            if (w_abort) begin
                r_state    <= ST_IDLE;
                r_grant    <= '0;
                r_ptr      <= w_nptr;
                r_core_rst <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_any) begin
                    r_state    <= ST_CRST;
                    r_grant    <= w_pick;
                    r_gidx     <= w_idx;
                    r_core_rst <= 1'b0;
                    r_txn      <= '{op:     i_term_op[w_idx*OP_W +: OP_W],
                                    acc:    i_term_acc[w_idx*ACC_W +: ACC_W],
                                    pin:    i_term_pin[w_idx*PIN_W +: PIN_W],
                                    newpin: i_term_newpin[w_idx*PIN_W +: PIN_W],
                                    amount: i_term_amount[w_idx*AMT_W +: AMT_W],
                                    lang:   i_term_lang[w_idx]};
                end
            end else if (r_state == ST_CRST) begin
                r_state <= ST_RUN;
                r_cnt   <= '0;
            end else if (r_state == ST_RUN) begin
                r_cnt <= r_cnt + 1'b1;
                if (w_expire) begin
                    r_state <= ST_RESP;
                    r_bal   <= i_core_balance;
                    r_succ  <= i_core_success;
                end
            end else begin
                r_state        <= ST_IDLE;
                r_grant        <= '0;
                r_done         <= r_grant;
                r_ptr          <= w_nptr;
                r_fail[r_gidx] <= r_succ ? '0 : (r_fail[r_gidx] == FW'(MAX_FAIL) ? r_fail[r_gidx] : w_fail_nxt);
                if (!r_succ && w_fail_nxt == FW'(MAX_FAIL)) r_locked[r_gidx] <= 1'b1;
            end
        end
    end
    assign o_term_grant  = r_grant;
    assign o_term_done   = r_done;
    assign o_term_locked = r_locked;
    assign o_rsp_balance = r_bal;
    assign o_rsp_success = r_succ;
    assign o_core_rst    = r_core_rst;
    assign o_core_op     = r_txn.op;
    assign o_core_acc    = r_txn.acc;
    assign o_core_pin    = r_txn.pin;
    assign o_core_newpin = r_txn.newpin;
    assign o_core_amount = r_txn.amount;
    assign o_core_lang   = r_txn.lang;
endmodule
